// File: rtl/regfile_pkg.sv
// Shared types and helpers for the banked register file: clear-engine states,
// default sizing with derived index widths, and the even-parity function.
package regfile_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int NREGS_DEF  = 16;
    localparam int NBANKS_DEF = 2;
    localparam int NRD_DEF    = 2;

    localparam int BANK_W     = $clog2(NBANKS_DEF);
    localparam int IDX_W      = $clog2(NREGS_DEF);

    // Widest word the parity helper accepts; callers zero-extend into it.
    localparam int PAR_MAX_W  = 64;

    typedef enum logic [1:0] {
        CLR_ALL = 2'd0,
        READY   = 2'd1,
        CLR_ONE = 2'd2
    } clr_state_e;

    // Returns the bit that makes data plus parity hold an even number of ones.
    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear engine: zeroes every bank after reset, then one requested bank at a
// time, one register per cycle starting at index 1 (index 0 is hardwired zero).
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int  NREGS  = NREGS_DEF,
    parameter int  NBANKS = NBANKS_DEF,
    localparam int BW     = $clog2(NBANKS),
    localparam int IW     = $clog2(NREGS)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clr_req,
    input  logic [BW-1:0] i_clr_bank,
    output clr_state_e    o_state,
    output logic [IW-1:0] o_idx,
    output logic [BW-1:0] o_bank,
    output logic          o_clr_stb,
    output logic          o_busy
);

    localparam logic [IW-1:0] IDX_FIRST = IW'(1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NREGS - 1);

    clr_state_e    r_state;
    clr_state_e    w_state_nxt;
    logic [IW-1:0] r_idx;
    logic [IW-1:0] w_idx_nxt;
    logic [BW-1:0] r_bank;
    logic [BW-1:0] w_bank_nxt;
    logic          w_clr_stb;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= CLR_ALL;
            r_idx   <= IDX_FIRST;
            r_bank  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_bank  <= w_bank_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_bank_nxt  = r_bank;
        w_clr_stb   = 1'b0;
        case (r_state)
            CLR_ALL, CLR_ONE: begin
                w_clr_stb = 1'b1;
                if (r_idx == IDX_LAST) begin
                    w_state_nxt = READY;
                    w_idx_nxt   = IDX_FIRST;
                end else begin
                    w_idx_nxt = r_idx + IW'(1);
                end
            end
            READY: begin
                if (i_clr_req) begin
                    w_state_nxt = CLR_ONE;
                    w_idx_nxt   = IDX_FIRST;
                    w_bank_nxt  = i_clr_bank;
                end
            end
            default: begin
                w_state_nxt = CLR_ALL;
                w_idx_nxt   = IDX_FIRST;
            end
        endcase
    end

    assign o_state   = r_state;
    assign o_idx     = r_idx;
    assign o_bank    = r_bank;
    assign o_clr_stb = w_clr_stb;
    assign o_busy    = (r_state != READY);

endmodule

// File: rtl/banked_regfile.sv
// Multi-bank register file with write-through read bypass, a cross-bank write
// port and a sequenced clear. Define BANKED_REGFILE_PARITY_EN for parity + rd_perr.
module banked_regfile
    import regfile_pkg::*;
#(
    parameter int  XLEN   = XLEN_DEF,
    parameter int  NREGS  = NREGS_DEF,
    parameter int  NBANKS = NBANKS_DEF,
    parameter int  NRD    = NRD_DEF,
    localparam int BW     = $clog2(NBANKS),
    localparam int IW     = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*BW-1:0]   rd_bank,
    input  logic [NRD*IW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    input  logic                wr_en,
    input  logic [BW-1:0]       wr_bank,
    input  logic [IW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                xb_en,
    input  logic [BW-1:0]       xb_bank,
    input  logic [IW-1:0]       xb_addr,
    input  logic [XLEN-1:0]     xb_data,
    input  logic                clr_req,
    input  logic [BW-1:0]       clr_bank,
    output logic                busy,
`ifdef BANKED_REGFILE_PARITY_EN
    output logic [NRD-1:0]      rd_perr,
`endif
    output logic                wr_drop
);

    logic [XLEN-1:0] r_mem [NBANKS][NREGS];
`ifdef BANKED_REGFILE_PARITY_EN
    logic            r_par [NBANKS][NREGS];
`endif
    logic            r_wr_drop;

    clr_state_e      w_state;
    logic [IW-1:0]   w_clr_idx;
    logic [BW-1:0]   w_clr_bank;
    logic            w_clr_stb;

    regfile_clear_seq #(
        .NREGS  (NREGS),
        .NBANKS (NBANKS)
    ) u_clear_seq (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_clr_req  (clr_req),
        .i_clr_bank (clr_bank),
        .o_state    (w_state),
        .o_idx      (w_clr_idx),
        .o_bank     (w_clr_bank),
        .o_clr_stb  (w_clr_stb),
        .o_busy     (busy)
    );

    // Index-0 writes are no-ops rather than drops; they never reach arbitration.
    logic w_wr_live, w_xb_live, w_wr_blk, w_xb_blk, w_coll, w_wr_ok, w_xb_ok;

    assign w_wr_live = wr_en && (wr_addr != '0);
    assign w_xb_live = xb_en && (xb_addr != '0);
    assign w_wr_blk  = w_wr_live && w_clr_stb && (w_state == CLR_ALL || w_clr_bank == wr_bank);
    assign w_xb_blk  = w_xb_live && w_clr_stb && (w_state == CLR_ALL || w_clr_bank == xb_bank);
    assign w_coll    = w_wr_live && w_xb_live && (wr_bank == xb_bank) && (wr_addr == xb_addr);
    assign w_wr_ok   = w_wr_live && !w_wr_blk;
    assign w_xb_ok   = w_xb_live && !w_xb_blk && !w_coll;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_drop <= 1'b0;
        end else begin
            r_wr_drop <= w_wr_blk || w_xb_blk || w_coll;
        end
    end

    assign wr_drop = r_wr_drop;

    // Blocked writes guarantee the clear never shares a bank with a write.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NBANKS; b++) begin
            if (w_clr_stb && (w_state == CLR_ALL || w_clr_bank == BW'(b))) begin
                r_mem[b][w_clr_idx] <= '0;
`ifdef BANKED_REGFILE_PARITY_EN
                r_par[b][w_clr_idx] <= 1'b0;
`endif
            end
            if (w_wr_ok && wr_bank == BW'(b)) begin
                r_mem[b][wr_addr] <= wr_data;
`ifdef BANKED_REGFILE_PARITY_EN
                r_par[b][wr_addr] <= even_parity(PAR_MAX_W'(wr_data));
`endif
            end
            if (w_xb_ok && xb_bank == BW'(b)) begin
                r_mem[b][xb_addr] <= xb_data;
`ifdef BANKED_REGFILE_PARITY_EN
                r_par[b][xb_addr] <= even_parity(PAR_MAX_W'(xb_data));
`endif
            end
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [BW-1:0]   w_rb;
        logic [IW-1:0]   w_ra;
        logic [XLEN-1:0] w_stored;
        logic            w_hit_wr;
        logic            w_hit_xb;

        assign w_rb     = rd_bank[p*BW +: BW];
        assign w_ra     = rd_addr[p*IW +: IW];
        assign w_stored = r_mem[w_rb][w_ra];
        assign w_hit_wr = w_wr_ok && (wr_bank == w_rb) && (wr_addr == w_ra);
        assign w_hit_xb = w_xb_ok && (xb_bank == w_rb) && (xb_addr == w_ra);

        assign rd_data[p*XLEN +: XLEN] = (w_ra == '0) ? '0      :
                                         w_hit_wr     ? wr_data :
                                         w_hit_xb     ? xb_data : w_stored;
`ifdef BANKED_REGFILE_PARITY_EN
        assign rd_perr[p] = (w_ra != '0) && !w_hit_wr && !w_hit_xb &&
                            (even_parity(PAR_MAX_W'(w_stored)) != r_par[w_rb][w_ra]);
`endif
    end

endmodule

// File: tb/tb_banked_regfile.sv
// Self-checking bench for banked_regfile (default sizing, parity feature off).
module tb_banked_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  rd_bank;
    logic [7:0]  rd_addr;
    logic [63:0] rd_data;
    logic        wr_en;
    logic [0:0]  wr_bank;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        xb_en;
    logic [0:0]  xb_bank;
    logic [3:0]  xb_addr;
    logic [31:0] xb_data;
    logic        clr_req;
    logic [0:0]  clr_bank;
    logic        busy;
    logic        wr_drop;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] model [2][16];
    logic [31:0] exp_q [$];
    logic [0:0]  drop_q [$];

    banked_regfile dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_bank  (rd_bank),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_bank  (wr_bank),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .xb_en    (xb_en),
        .xb_bank  (xb_bank),
        .xb_addr  (xb_addr),
        .xb_data  (xb_data),
        .clr_req  (clr_req),
        .clr_bank (clr_bank),
        .busy     (busy),
        .wr_drop  (wr_drop)
    );

    // clock / reset
    always #5 clk = ~clk;

    // driver tasks
    task automatic drive_idle();
        wr_en   = 1'b0;  wr_bank = '0; wr_addr = '0; wr_data = '0;
        xb_en   = 1'b0;  xb_bank = '0; xb_addr = '0; xb_data = '0;
        clr_req = 1'b0;  clr_bank = '0;
    endtask

    task automatic set_rd(input int p, input int b, input int a);
        rd_bank[p]         = 1'(b);
        rd_addr[p*4 +: 4]  = 4'(a);
    endtask

    task automatic model_zero();
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < 16; r++)
                model[b][r] = '0;
    endtask

    // Waits edge by edge until busy falls; returns the edge count or -1 on timeout.
    task automatic count_busy(output int n);
        n = -1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (!busy) begin
                n = k;
                break;
            end
        end
    endtask

    // Reference read with write-through priority (primary, then cross-bank).
    function automatic logic [31:0] pred_rd(input int b, input int a);
        if (a == 0) return '0;
        if (wr_en && wr_addr != 0 && int'(wr_bank) == b && int'(wr_addr) == a) return wr_data;
        if (xb_en && xb_addr != 0 && int'(xb_bank) == b && int'(xb_addr) == a) return xb_data;
        return model[b][a];
    endfunction

    task automatic test_reset();
        int          n;
        logic [31:0] got, want;
        drive_idle();
        set_rd(0, 0, 0); set_rd(1, 1, 0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL reset_busy: got %b want 1", busy); end
        total++;
        if (wr_drop !== 1'b0) begin bad++; $display("FAIL reset_wr_drop: got %b want 0", wr_drop); end
        rst_n = 1'b1;
        count_busy(n);
        total++;
        if (n !== 15) begin bad++; $display("FAIL reset_busy_len: got %0d want 15", n); end
        model_zero();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            set_rd(0, 0, i); set_rd(1, 1, i);
            #1;
            exp_q.push_back(pred_rd(0, i));
            exp_q.push_back(pred_rd(1, i));
            for (int p = 0; p < 2; p++) begin
                got  = rd_data[p*32 +: 32];
                want = exp_q.pop_front();
                total++;
                if (got !== want) begin bad++; $display("FAIL reset_read p%0d r%0d: got %h want %h", p, i, got, want); end
            end
        end
    endtask

    task automatic test_bypass();
        logic [31:0] got;
        @(posedge clk); #1;
        wr_en = 1'b1; wr_bank = 1'b1; wr_addr = 4'd5; wr_data = 32'hDEADBEEF;
        set_rd(0, 1, 5); set_rd(1, 0, 5);
        #1;
        exp_q.push_back(32'hDEADBEEF);
        exp_q.push_back(32'h0);
        got = rd_data[31:0];
        total++;
        if (got !== exp_q[0]) begin bad++; $display("FAIL bypass_p0: got %h want %h", got, exp_q[0]); end
        void'(exp_q.pop_front());
        got = rd_data[63:32];
        total++;
        if (got !== exp_q[0]) begin bad++; $display("FAIL bypass_p1: got %h want %h", got, exp_q[0]); end
        void'(exp_q.pop_front());
        model[1][5] = 32'hDEADBEEF;
        @(posedge clk); #1;
        drive_idle();
        #1;
        got = rd_data[31:0];
        total++;
        if (got !== 32'hDEADBEEF) begin bad++; $display("FAIL bypass_commit: got %h want deadbeef", got); end
        total++;
        if (wr_drop !== 1'b0) begin bad++; $display("FAIL bypass_no_drop: got %b want 0", wr_drop); end
    endtask

    task automatic test_xb_bypass();
        logic [31:0] got, want;
        @(posedge clk); #1;
        xb_en = 1'b1; xb_bank = 1'b1; xb_addr = 4'd9; xb_data = 32'h0000_5555;
        set_rd(0, 1, 9); set_rd(1, 0, 9);
        #1;
        exp_q.push_back(pred_rd(1, 9));
        got = rd_data[31:0]; want = exp_q.pop_front();
        total++;
        if (got !== want) begin bad++; $display("FAIL xb_bypass: got %h want %h", got, want); end
        model[1][9] = 32'h0000_5555;
        @(posedge clk); #1;
        drive_idle();
        #1;
        got = rd_data[31:0];
        total++;
        if (got !== 32'h0000_5555) begin bad++; $display("FAIL xb_commit: got %h want 00005555", got); end
    endtask

    task automatic test_collision();
        logic [31:0] got;
        @(posedge clk); #1;
        wr_en = 1'b1; wr_bank = 1'b0; wr_addr = 4'd3; wr_data = 32'h11;
        xb_en = 1'b1; xb_bank = 1'b0; xb_addr = 4'd3; xb_data = 32'h22;
        set_rd(0, 0, 3);
        #1;
        got = rd_data[31:0];
        total++;
        if (got !== 32'h11) begin bad++; $display("FAIL coll_bypass: got %h want 00000011", got); end
        model[0][3] = 32'h11;
        @(posedge clk); #1;
        drive_idle();
        total++;
        if (wr_drop !== 1'b1) begin bad++; $display("FAIL coll_drop: got %b want 1", wr_drop); end
        #1;
        got = rd_data[31:0];
        total++;
        if (got !== 32'h11) begin bad++; $display("FAIL coll_value: got %h want 00000011", got); end
        @(posedge clk); #1;
        total++;
        if (wr_drop !== 1'b0) begin bad++; $display("FAIL coll_drop_pulse: got %b want 0", wr_drop); end
    endtask

    task automatic test_reg0();
        logic [31:0] got;
        @(posedge clk); #1;
        wr_en = 1'b1; wr_bank = 1'b0; wr_addr = 4'd0; wr_data = 32'hFFFFFFFF;
        set_rd(0, 0, 0); set_rd(1, 1, 0);
        #1;
        got = rd_data[31:0];
        total++;
        if (got !== 32'h0) begin bad++; $display("FAIL reg0_bypass: got %h want 0", got); end
        @(posedge clk); #1;
        drive_idle();
        total++;
        if (wr_drop !== 1'b0) begin bad++; $display("FAIL reg0_drop: got %b want 0", wr_drop); end
        got = rd_data[31:0];
        total++;
        if (got !== 32'h0) begin bad++; $display("FAIL reg0_value: got %h want 0", got); end
    endtask

    task automatic test_back_to_back();
        int          rb [2];
        int          ra [2];
        logic [31:0] got, want;
        logic [0:0]  dexp;
        logic        coll;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (drop_q.size() > 0) begin
                dexp = drop_q.pop_front();
                total++;
                if (wr_drop !== dexp) begin bad++; $display("FAIL b2b_drop k%0d: got %b want %b", k, wr_drop, dexp); end
            end
            wr_en   = 1'($urandom_range(0, 1));
            wr_bank = 1'($urandom_range(0, 1));
            wr_addr = 4'($urandom_range(0, 7));
            wr_data = $urandom;
            xb_en   = 1'($urandom_range(0, 1));
            xb_bank = 1'($urandom_range(0, 1));
            xb_addr = 4'($urandom_range(0, 7));
            xb_data = $urandom;
            for (int p = 0; p < 2; p++) begin
                rb[p] = $urandom_range(0, 1);
                ra[p] = $urandom_range(0, 7);
                set_rd(p, rb[p], ra[p]);
            end
            #1;
            for (int p = 0; p < 2; p++) exp_q.push_back(pred_rd(rb[p], ra[p]));
            for (int p = 0; p < 2; p++) begin
                got  = rd_data[p*32 +: 32];
                want = exp_q.pop_front();
                total++;
                if (got !== want) begin bad++; $display("FAIL b2b_rd k%0d p%0d: got %h want %h", k, p, got, want); end
            end
            coll = wr_en && xb_en && wr_addr != 0 && wr_bank == xb_bank && wr_addr == xb_addr;
            drop_q.push_back(coll);
            if (wr_en && wr_addr != 0) model[wr_bank][wr_addr] = wr_data;
            if (xb_en && xb_addr != 0 && !coll) model[xb_bank][xb_addr] = xb_data;
        end
        @(posedge clk); #1;
        drive_idle();
        dexp = drop_q.pop_front();
        total++;
        if (wr_drop !== dexp) begin bad++; $display("FAIL b2b_drop_last: got %b want %b", wr_drop, dexp); end
    endtask

    task automatic test_clear_one();
        int          n;
        logic [31:0] got, want;
        for (int i = 1; i < 16; i++) begin
            @(posedge clk); #1;
            wr_en = 1'b1; wr_bank = 1'b0; wr_addr = 4'(i); wr_data = 32'hA5A5A5A5;
            xb_en = 1'b1; xb_bank = 1'b1; xb_addr = 4'(i); xb_data = $urandom;
            model[0][i] = 32'hA5A5A5A5;
            model[1][i] = xb_data;
        end
        @(posedge clk); #1;
        drive_idle();
        clr_req = 1'b1; clr_bank = 1'b0;
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL clr_busy_start: got %b want 1", busy); end
        // this request arrives while busy and must be ignored
        clr_req = 1'b1; clr_bank = 1'b1;
        wr_en = 1'b1; wr_bank = 1'b0; wr_addr = 4'd7; wr_data = 32'h1234;
        xb_en = 1'b1; xb_bank = 1'b1; xb_addr = 4'd7; xb_data = 32'h777;
        set_rd(0, 0, 7); set_rd(1, 1, 7);
        #1;
        got = rd_data[31:0];
        total++;
        if (got !== 32'hA5A5A5A5) begin bad++; $display("FAIL clr_stale_read: got %h want a5a5a5a5", got); end
        got = rd_data[63:32];
        total++;
        if (got !== 32'h777) begin bad++; $display("FAIL clr_other_bypass: got %h want 00000777", got); end
        model[1][7] = 32'h777;
        @(posedge clk); #1;
        drive_idle();
        total++;
        if (wr_drop !== 1'b1) begin bad++; $display("FAIL clr_drop: got %b want 1", wr_drop); end
        count_busy(n);
        total++;
        if (n !== 14) begin bad++; $display("FAIL clr_busy_len: got %0d want 14", n); end
        for (int i = 0; i < 16; i++) model[0][i] = '0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            set_rd(0, 0, i); set_rd(1, 1, i);
            #1;
            exp_q.push_back(pred_rd(0, i));
            exp_q.push_back(pred_rd(1, i));
            for (int p = 0; p < 2; p++) begin
                got  = rd_data[p*32 +: 32];
                want = exp_q.pop_front();
                total++;
                if (got !== want) begin bad++; $display("FAIL clr_read p%0d r%0d: got %h want %h", p, i, got, want); end
            end
        end
    endtask

    task automatic test_reset_midclear();
        int          n;
        logic [31:0] got, want;
        @(posedge clk); #1;
        clr_req = 1'b1; clr_bank = 1'b1;
        @(posedge clk); #1;
        clr_req = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy: got %b want 1", busy); end
        total++;
        if (wr_drop !== 1'b0) begin bad++; $display("FAIL mid_drop: got %b want 0", wr_drop); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        count_busy(n);
        total++;
        if (n !== 15) begin bad++; $display("FAIL mid_busy_len: got %0d want 15", n); end
        model_zero();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            set_rd(0, 0, i); set_rd(1, 1, i);
            #1;
            exp_q.push_back(pred_rd(0, i));
            exp_q.push_back(pred_rd(1, i));
            for (int p = 0; p < 2; p++) begin
                got  = rd_data[p*32 +: 32];
                want = exp_q.pop_front();
                total++;
                if (got !== want) begin bad++; $display("FAIL mid_read p%0d r%0d: got %h want %h", p, i, got, want); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_xb_bypass();
        test_collision();
        test_reg0();
        test_back_to_back();
        test_clear_one();
        test_reset_midclear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/banked_regfile.md
Name: banked_regfile

Overview:
- Parametrised, multi-bank integer register file for the pipelined RISC-V core.
- Generalises the fixed two-bank normal/dual-mode register array to NBANKS banks and NRD read ports.
- Adds per-read-port write-through bypass, a cross-bank supervisor write port, and a sequenced clear engine.
- Sits between ID (read) and WB (write); the dual-mode firmware path uses the cross-bank port.

Parameters:
- XLEN, 32, register width in bits.
- NREGS, 16, registers per bank; power of two, at least 2.
- NBANKS, 2, number of banks (modes); at least 2.
- NRD, 2, number of read ports.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous, active-low reset.
- rd_bank  in  NRD*$clog2(NBANKS)  bank per read port.
- rd_addr  in  NRD*$clog2(NREGS)  register index per read port.
- rd_data  out  NRD*XLEN  read data per port.
- wr_en  in  1  primary (WB) write strobe.
- wr_bank  in  $clog2(NBANKS)  primary write bank.
- wr_addr  in  $clog2(NREGS)  primary write index.
- wr_data  in  XLEN  primary write data.
- xb_en  in  1  cross-bank (supervisor) write strobe.
- xb_bank  in  $clog2(NBANKS)  cross-bank target bank.
- xb_addr  in  $clog2(NREGS)  cross-bank target index.
- xb_data  in  XLEN  cross-bank write data.
- clr_req  in  1  request to clear one bank.
- clr_bank  in  $clog2(NBANKS)  bank to clear.
- busy  out  1  clear sequence active.
- wr_drop  out  1  one-cycle pulse: a write was discarded.

Behaviour:
- Register 0 of every bank reads 0 at all times. Writes to index 0 are discarded silently (no wr_drop).
- Reads are combinational. If wr_en is high and (wr_bank, wr_addr) equals a port's (rd_bank, rd_addr) with a non-zero index, that port returns wr_data in the same cycle (bypass).
- Otherwise, if xb_en matches the same location, the port returns xb_data.
- Otherwise the port returns the stored value.
- Writes commit on posedge clk.
- If the primary and cross-bank writes target the same location in the same cycle, the primary write wins, the cross-bank data is lost, and wr_drop pulses.
- State machine states: CLR_ALL, READY, CLR_ONE.
- rst_n low (asynchronous):
  - state = CLR_ALL, idx = 1, busy = 1, wr_drop = 0.
  - The array contents are not reset directly.
- CLR_ALL:
  - Each cycle writes 0 to index idx in every bank, then increments idx.
  - When idx = NREGS-1 has been written, the next state is READY and busy = 0.
  - Duration is NREGS-1 cycles after rst_n deasserts.
- READY: when clr_req is sampled high, latch clr_bank, set idx = 1, enter CLR_ONE, and assert busy from the next cycle.
- CLR_ONE:
  - Zeroes one register per cycle in the latched bank only.
  - Returns to READY after index NREGS-1 is written.
  - Other banks stay fully readable and writable.
- While busy:
  - Primary or cross-bank writes to a bank being cleared are discarded, with wr_drop pulsed.
  - Reads of a bank being cleared return the stored value: either the stale value or 0, depending on clear progress.
  - clr_req is ignored.
- A clr_req in the same cycle as a write to that bank: the write commits, and the clear then zeroes the register later.
- Reset asserted mid-clear: the FSM restarts CLR_ALL immediately.
- Index arithmetic is unsigned, $clog2(NREGS) bits wide, with no wrap beyond NREGS-1.

Optional Feature:
- Macro: BANKED_REGFILE_PARITY_EN.
- When defined:
  - Each register stores an extra even-parity bit computed on write.
  - An extra output rd_perr [NRD] asserts combinationally when a read of a non-bypassed, non-zero index has mismatching parity.
  - The clear engine writes parity 0.
- When undefined: no parity storage and no rd_perr port.

Decomposition:
- Package regfile_pkg holds:
  - the state enum {CLR_ALL, READY, CLR_ONE};
  - width helper localparams BANK_W and IDX_W as $clog2 expressions;
  - a parity function.
- One sub-module, regfile_clear_seq, owns the FSM, idx counter, latched bank, busy, and a per-cycle clear strobe.
- banked_regfile owns the storage, bypass muxing and write arbitration.

Test Plan:
- Reset then idle, NREGS = 16, NBANKS = 2 → busy high for exactly 15 cycles after rst_n rises; all 32 locations read 0 afterwards.
- Write bank 1, reg 5 = 0xDEADBEEF while port 0 reads bank 1, reg 5 in the same cycle → rd_data[0] = 0xDEADBEEF combinationally; port 1 reading bank 0, reg 5 → 0.
- wr_en and xb_en both target bank 0, reg 3, with data 0x11 and 0x22 → reg 3 = 0x11 next cycle; wr_drop pulses for 1 cycle.
- Bank 0 filled with 0xA5; clr_req for bank 0; write bank 0, reg 7 during busy → write dropped with wr_drop pulse; bank 1 write accepted; after 15 cycles bank 0 reads all 0.
- Write 0xFFFFFFFF to reg 0 → reads stay 0; no wr_drop.
- Assert rst_n low at idx = 8 of CLR_ONE → busy stays high; CLR_ALL runs a full 15 cycles; every bank reads 0.
